// File: rtl/clint_pkg.sv
// clint_pkg: shared CLINT types and helpers used by the RTC reference generator
package clint_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PEND
   } rtc_gen_state_e;

   // Rounded phase increment so that clk_hz * inc / 2^w approximates rtc_hz
   function automatic logic [63:0] rtc_inc(input logic [63:0] clk_hz,
                                           input logic [63:0] rtc_hz,
                                           input int unsigned w);
      return ((rtc_hz << w) + (clk_hz >> 1)) / clk_hz;
   endfunction

endpackage

// File: rtl/clint_rtc_gen.sv
// clint_rtc_gen: NCO-based RTC square-wave source for the CLINT rtc_i input, retunable at period boundaries
module clint_rtc_gen
   import clint_pkg::*;
#(
   parameter int unsigned     ACC_WIDTH   = 32,
   parameter longint unsigned CLK_FREQ_HZ = 50_000_000,
   parameter longint unsigned RTC_FREQ_HZ = 32_768
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [ACC_WIDTH-1:0] cfg_inc_i,
   output logic                 cfg_err_o,
   output logic [ACC_WIDTH-1:0] inc_o,
   output logic                 rtc_o,
   output logic                 tick_o
);

   localparam int unsigned            MSB       = ACC_WIDTH - 1;
   localparam logic [63:0]            INC_DEF64 = rtc_inc(CLK_FREQ_HZ, RTC_FREQ_HZ, ACC_WIDTH);
   localparam logic [ACC_WIDTH-1:0]   INC_DEF   = INC_DEF64[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0]   INC_MAX   = {2'b01, {(ACC_WIDTH-2){1'b0}}};

   if (ACC_WIDTH < 16 || ACC_WIDTH > 40) begin : g_bad_width
      $error("clint_rtc_gen: ACC_WIDTH must be within 16..40");
   end
   if (4 * RTC_FREQ_HZ > CLK_FREQ_HZ) begin : g_bad_freq
      $error("clint_rtc_gen: RTC_FREQ_HZ must not exceed CLK_FREQ_HZ/4");
   end

   rtc_gen_state_e       state_q, state_n;
   logic [ACC_WIDTH-1:0] acc_q, acc_sum, acc_n;
   logic [ACC_WIDTH-1:0] inc_q, inc_n;
   logic [ACC_WIDTH-1:0] pend_q, pend_n;
   logic                 wrap, accept, legal, load;
   logic                 tick_q, tick_n;
   logic                 err_q, err_n;

   assign {wrap, acc_sum} = {1'b0, acc_q} + {1'b0, inc_q};
   assign acc_n           = en_i ? acc_sum : acc_q;
   assign tick_n          = en_i & ~acc_q[MSB] & acc_sum[MSB];
   assign cfg_ready_o     = state_q != PEND;
   assign accept          = cfg_valid_i & cfg_ready_o;
   assign legal           = (cfg_inc_i != '0) && (cfg_inc_i <= INC_MAX);
   assign load            = accept & legal;
   assign err_n           = accept & ~legal;

   assign rtc_o     = acc_q[MSB];
   assign tick_o    = tick_q;
   assign cfg_err_o = err_q;
   assign inc_o     = inc_q;

   // Next-state and increment selection: updates while running wait for a carry-out so phase stays continuous
   always_comb begin
      state_n = state_q;
      inc_n   = inc_q;
      pend_n  = pend_q;
      unique case (state_q)
         IDLE: begin
            inc_n   = load ? cfg_inc_i : inc_q;
            state_n = en_i ? RUN : IDLE;
         end
         RUN: begin
            if (!en_i) begin
               inc_n   = load ? cfg_inc_i : inc_q;
               state_n = IDLE;
            end else if (load) begin
               pend_n  = cfg_inc_i;
               state_n = PEND;
            end
         end
         PEND: begin
            if (!en_i) begin
               inc_n   = pend_q;
               state_n = IDLE;
            end else if (wrap) begin
               inc_n   = pend_q;
               state_n = RUN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, accumulator and pulse registers; reset discards any pending update
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         inc_q   <= INC_DEF;
         pend_q  <= '0;
         tick_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         acc_q   <= acc_n;
         inc_q   <= inc_n;
         pend_q  <= pend_n;
         tick_q  <= tick_n;
         err_q   <= err_n;
      end
   end

endmodule

// File: tb/tb_clint_rtc_gen.sv
// tb_clint_rtc_gen: scoreboard bench comparing the RTC generator against a phase-arithmetic reference model
module tb_clint_rtc_gen;

   localparam longint unsigned MOD     = 64'd1 << 32;
   localparam longint unsigned HALF    = MOD >> 1;
   localparam logic [31:0]     INC_DEF = 32'h002A_F31E;
   localparam int              N_LONG  = 50000;

   typedef struct {
      int          cyc;
      bit          rtc;
      bit          tick;
      bit          ready;
      bit          err;
      logic [31:0] inc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic        cfg_valid_i = 1'b0;
   logic [31:0] cfg_inc_i = '0;
   logic        cfg_ready_o, cfg_err_o, rtc_o, tick_o;
   logic [31:0] inc_o;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   bit   cnt_on = 1'b0;
   int   tick_cnt = 0;

   longint unsigned m_phase = 0;
   logic [31:0]     m_inc = INC_DEF;
   logic [31:0]     m_pend = '0;
   bit              m_pv = 1'b0;
   bit              m_prev_en = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   clint_rtc_gen #(.ACC_WIDTH(32), .CLK_FREQ_HZ(50_000_000), .RTC_FREQ_HZ(32_768)) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .en_i(en_i),
      .cfg_valid_i(cfg_valid_i),
      .cfg_ready_o(cfg_ready_o),
      .cfg_inc_i(cfg_inc_i),
      .cfg_err_o(cfg_err_o),
      .inc_o(inc_o),
      .rtc_o(rtc_o),
      .tick_o(tick_o)
   );

   // Drive one cycle of inputs and push what the outputs must read after the next edge
   task automatic step(input bit r, input bit e, input bit v, input logic [31:0] c);
      exp_t            x;
      longint unsigned sum;
      bit              acc, legal, wrapped;
      @(posedge clk);
      #1;
      rst_i = r;
      en_i = e;
      cfg_valid_i = v;
      cfg_inc_i = c;
      if (r) begin
         m_phase = 0;
         m_inc = INC_DEF;
         m_pv = 1'b0;
         m_prev_en = 1'b0;
         x.tick = 1'b0;
         x.err = 1'b0;
      end else begin
         acc = v && !m_pv;
         legal = (c != 0) && (c <= 32'h4000_0000);
         x.err = acc && !legal;
         sum = m_phase + longint'(m_inc);
         wrapped = e && (sum >= MOD);
         x.tick = e && (m_phase < HALF) && ((sum % MOD) >= HALF);
         if (m_pv) begin
            if (!e || wrapped) begin
               m_inc = m_pend;
               m_pv = 1'b0;
            end
         end else if (acc && legal) begin
            if (m_prev_en && e) begin
               m_pend = c;
               m_pv = 1'b1;
            end else begin
               m_inc = c;
            end
         end
         if (e) m_phase = sum % MOD;
         m_prev_en = e;
      end
      x.rtc = m_phase >= HALF;
      x.ready = !m_pv;
      x.inc = m_inc;
      x.cyc = cyc + 1;
      sbq.push_back(x);
   endtask

   // Monitor: pop every expectation that has come due and compare with the DUT outputs
   initial begin : mon
      exp_t x;
      forever begin
         @(negedge clk);
         if (cnt_on && tick_o === 1'b1) tick_cnt++;
         while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            x = sbq.pop_front();
            checks++;
            if ({rtc_o, tick_o, cfg_ready_o, cfg_err_o, inc_o} !== {x.rtc, x.tick, x.ready, x.err, x.inc}) begin
               failures++;
               $display("FAIL sb cyc=%0d got rtc=%b tick=%b rdy=%b err=%b inc=%h want rtc=%b tick=%b rdy=%b err=%b inc=%h",
                        x.cyc, rtc_o, tick_o, cfg_ready_o, cfg_err_o, inc_o, x.rtc, x.tick, x.ready, x.err, x.inc);
            end
         end
      end
   end

   initial begin
      longint unsigned want_ticks;
      logic [31:0]     c;
      repeat (3) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'h4000_0000);
      repeat (12) step(0, 1, 0, 0);
      step(0, 1, 1, 32'h8000_0001);
      step(0, 1, 0, 0);
      step(0, 1, 1, 32'h0000_0000);
      repeat (3) step(0, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         if (m_phase == 64'h4000_0000) begin
            step(0, 1, 1, 32'h2000_0000);
            break;
         end
         step(0, 1, 0, 0);
      end
      repeat (12) step(0, 1, 1, 32'h1000_0000);
      repeat (20) step(0, 1, 0, 0);
      for (int i = 0; i < 64 && m_phase < HALF; i++) step(0, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0);
      step(0, 0, 1, 32'h0800_0000);
      repeat (7) step(0, 0, 0, 0);
      repeat (6) step(0, 1, 0, 0);
      step(0, 1, 1, 32'h3000_0000);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      cnt_on = 1'b1;
      repeat (N_LONG - 1) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      cnt_on = 1'b0;
      want_ticks = (longint'(N_LONG) * longint'(INC_DEF) + HALF) / MOD;
      checks++;
      if (longint'(tick_cnt) != want_ticks) begin
         failures++;
         $display("FAIL mtime_count got=%0d want=%0d", tick_cnt, want_ticks);
      end
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 5))
            0:       c = 32'h0000_0000;
            1:       c = 32'h4000_0000;
            2:       c = 32'h4000_0001;
            3:       c = $urandom;
            default: c = $urandom_range(32'h4000_0000, 32'h0100_0000);
         endcase
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, c);
      end
      step(0, 0, 0, 0);
      repeat (4) @(posedge clk);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d want=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
